// File: rtl/rx_iq_packer.sv
`default_nettype none
// ============================================================================
// Module   : rx_iq_packer
// Brief    : Packs pairs of 24-bit {Q,I} RX FIFO words into three 16-bit host
//            words, with a sticky overrun flag and a wrapping group counter.
// Revision : 1.0 - initial release
// ============================================================================
module rx_iq_packer #(
  parameter int IQ_PAIR_WIDTH = 24,
  parameter int OUT_WIDTH     = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     rx_fifo_empty,
  input  logic                     rx_fifo_full,
  output logic                     rx_fifo_rd,
  input  logic [IQ_PAIR_WIDTH-1:0] rx_fifo_q,
  input  logic                     host_full,
  output logic                     host_wr,
  output logic [OUT_WIDTH-1:0]     host_data,
  output logic                     overrun,
  output logic [CNT_WIDTH-1:0]     group_cnt
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_cap_a = 3'd1;
  localparam logic [2:0] c_req_b = 3'd2;
  localparam logic [2:0] c_cap_b = 3'd3;
  localparam logic [2:0] c_w0    = 3'd4;
  localparam logic [2:0] c_w1    = 3'd5;
  localparam logic [2:0] c_w2    = 3'd6;

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]               r_state;
  logic [IQ_PAIR_WIDTH-1:0] r_a;
  logic [IQ_PAIR_WIDTH-1:0] r_b;
  logic                     r_overrun;
  logic [CNT_WIDTH-1:0]     r_group_cnt;

  logic                     w_rd;
  logic                     w_wr;
  logic [OUT_WIDTH-1:0]     w_data;

  // Little-endian byte stream: A bytes 0..2 then B bytes 0..2, two bytes per word.
  always_comb begin
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    w_data = '0;
    case (r_state)
      c_idle:  w_rd = enable & ~rx_fifo_empty;
      c_req_b: w_rd = enable & ~rx_fifo_empty;
      c_w0: begin
        w_wr   = ~host_full;
        w_data = r_a[15:0];
      end
      c_w1: begin
        w_wr   = ~host_full;
        w_data = {r_b[7:0], r_a[23:16]};
      end
      c_w2: begin
        w_wr   = ~host_full;
        w_data = r_b[23:8];
      end
      default: begin
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        w_data = '0;
      end
    endcase
  end

  // Strobes are forced low for the whole duration of an asserted reset.
  assign rx_fifo_rd = w_rd & reset_n;
  assign host_wr    = w_wr & reset_n;
  assign host_data  = reset_n ? w_data : '0;
  assign overrun    = r_overrun;
  assign group_cnt  = r_group_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= c_idle;
      r_a         <= '0;
      r_b         <= '0;
      r_group_cnt <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_rd) r_state <= c_cap_a;
        end
        c_cap_a: begin
          r_a     <= rx_fifo_q;
          r_state <= c_req_b;
        end
        c_req_b: begin
          // Dropping enable here abandons the half-built group.
          if (!enable)   r_state <= c_idle;
          else if (w_rd) r_state <= c_cap_b;
        end
        c_cap_b: begin
          r_b     <= rx_fifo_q;
          r_state <= c_w0;
        end
        c_w0: begin
          if (w_wr) r_state <= c_w1;
        end
        c_w1: begin
          if (w_wr) r_state <= c_w2;
        end
        c_w2: begin
          if (w_wr) begin
            r_group_cnt <= r_group_cnt + c_cnt_one;
            r_state     <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  r_overrun <= 1'b0;
    else if (enable & rx_fifo_full) r_overrun <= 1'b1;
    else if (!enable)              r_overrun <= 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_iq_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_iq_packer
// Brief    : Scoreboard bench for rx_iq_packer with an RX FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_iq_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        rx_fifo_full;
  logic        host_full;
  logic        force_empty;
  logic        rx_fifo_empty;
  logic        rx_fifo_rd;
  logic [23:0] rx_fifo_q = '0;
  logic        host_wr;
  logic [15:0] host_data;
  logic        overrun;
  logic [7:0]  group_cnt;

  logic [23:0] src_mem [0:1023];
  int          wr_idx = 0;
  int          rd_idx = 0;
  logic        rd_pend = 1'b0;
  int          cyc = 0;

  int          checks = 0;
  int          failures = 0;

  logic [15:0] exp_q [$];
  int          phase;
  logic [23:0] held_a;
  int          wr_count = 0;
  int          rd_count = 0;
  logic [15:0] wr_data [0:4095];
  int          wr_cyc  [0:4095];

  always #5 clk = ~clk;

  assign rx_fifo_empty = (rd_idx == wr_idx) || force_empty;

  rx_iq_packer #(
    .IQ_PAIR_WIDTH(24),
    .OUT_WIDTH(16),
    .CNT_WIDTH(8)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .rx_fifo_empty(rx_fifo_empty),
    .rx_fifo_full (rx_fifo_full),
    .rx_fifo_rd   (rx_fifo_rd),
    .rx_fifo_q    (rx_fifo_q),
    .host_full    (host_full),
    .host_wr      (host_wr),
    .host_data    (host_data),
    .overrun      (overrun),
    .group_cnt    (group_cnt)
  );

  // Registered-output RX FIFO: a read seen this cycle presents data next cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_pend) begin
      rx_fifo_q <= src_mem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end
  end

  // Monitor and reference model: two pairs read back-to-back form six
  // little-endian bytes, emitted as three 16-bit words.
  initial begin : monitor
    logic [15:0] e;
    logic [7:0]  bytes [0:5];
    logic [23:0] pb;
    phase = 0;
    forever begin
      @(negedge clk);
      rd_pend = rx_fifo_rd;
      if (!reset_n) begin
        phase = 0;
        exp_q.delete();
      end else begin
        if (host_wr) begin
          checks++;
          if (host_full) begin
            failures++;
            $display("FAIL wr_while_full cycle=%0d host_full=%b required=0", cyc, host_full);
          end
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write cycle=%0d actual=%h required=none", cyc, host_data);
          end else begin
            e = exp_q.pop_front();
            if (host_data !== e) begin
              failures++;
              $display("FAIL word cycle=%0d actual=%h required=%h", cyc, host_data, e);
            end
          end
          wr_data[wr_count] = host_data;
          wr_cyc[wr_count]  = cyc;
          wr_count++;
        end
        if (rx_fifo_rd) begin
          checks++;
          rd_count++;
          if (rx_fifo_empty) begin
            failures++;
            $display("FAIL rd_while_empty cycle=%0d empty=%b required=0", cyc, rx_fifo_empty);
          end
        end
        if (phase == 2 && !enable) begin
          phase = 0;
        end else if (phase == 1) begin
          if (rx_fifo_rd) begin
            checks++;
            failures++;
            $display("FAIL rd_during_capture cycle=%0d rd=%b required=0", cyc, rx_fifo_rd);
          end
          phase = 2;
        end else if (rx_fifo_rd) begin
          if (phase == 0) begin
            held_a = src_mem[rd_idx];
            phase  = 1;
          end else begin
            pb = src_mem[rd_idx];
            for (int k = 0; k < 3; k++) begin
              bytes[k]   = held_a[8*k +: 8];
              bytes[k+3] = pb[8*k +: 8];
            end
            for (int k = 0; k < 3; k++) exp_q.push_back({bytes[2*k+1], bytes[2*k]});
            phase = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_pair(input logic [23:0] p);
    src_mem[wr_idx] = p;
    wr_idx++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int target, input int budget);
    int n;
    n = 0;
    while (wr_count < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (wr_count < target) begin
      failures++;
      $display("FAIL wait_words_timeout actual=%0d required=%0d", wr_count, target);
    end
  endtask

  initial begin : driver
    int base;
    int r0;
    int n;
    reset_n      = 1'b0;
    enable       = 1'b1;
    host_full    = 1'b0;
    rx_fifo_full = 1'b0;
    force_empty  = 1'b0;
    push_pair(24'h111111);
    push_pair(24'h222222);

    @(negedge clk);
    chk("reset_rd", {31'd0, rx_fifo_rd}, 32'd0);
    chk("reset_wr", {31'd0, host_wr}, 32'd0);
    chk("reset_data", {16'd0, host_data}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    chk("reset_group_cnt", {24'd0, group_cnt}, 32'd0);
    cycles(1);
    reset_n = 1'b1;
    wait_words(3, 60);

    // Directed group with known packing
    base = wr_count;
    push_pair(24'hABC123);
    push_pair(24'h456DEF);
    wait_words(base + 3, 60);
    chk("t1_w0", {16'd0, wr_data[base]},   32'h0000C123);
    chk("t1_w1", {16'd0, wr_data[base+1]}, 32'h0000EFAB);
    chk("t1_w2", {16'd0, wr_data[base+2]}, 32'h0000456D);
    chk("t1_consecutive", wr_cyc[base+2] - wr_cyc[base], 32'd2);
    cycles(3);
    chk("t1_group_cnt", {24'd0, group_cnt}, 32'd2);

    // Host full held for 5 cycles while W1 is pending
    base = wr_count;
    push_pair(24'hABC123);
    push_pair(24'h456DEF);
    wait_words(base + 1, 60);
    host_full = 1'b1;
    cycles(5);
    chk("t2_w1_held", wr_count, base + 1);
    host_full = 1'b0;
    wait_words(base + 3, 60);
    chk("t2_w1", {16'd0, wr_data[base+1]}, 32'h0000EFAB);
    chk("t2_w2", {16'd0, wr_data[base+2]}, 32'h0000456D);
    cycles(3);
    chk("t2_group_cnt", {24'd0, group_cnt}, 32'd3);

    // Disable while waiting for the second pair: half group dropped
    base = wr_count;
    r0   = rd_count;
    push_pair(24'hA13333);
    cycles(6);
    chk("t3_first_read", rd_count, r0 + 1);
    enable = 1'b0;
    cycles(4);
    chk("t3_no_write", wr_count, base);
    push_pair(24'h5A5A5A);
    push_pair(24'h123456);
    cycles(3);
    chk("t3_no_rd_disabled", rd_count, r0 + 1);
    enable = 1'b1;
    wait_words(base + 3, 60);
    chk("t3_w0", {16'd0, wr_data[base]},   32'h00005A5A);
    chk("t3_w1", {16'd0, wr_data[base+1]}, 32'h0000565A);
    chk("t3_w2", {16'd0, wr_data[base+2]}, 32'h00001234);

    // Disable while stalled in W0: group still completes, no new reads
    base      = wr_count;
    r0        = rd_count;
    host_full = 1'b1;
    push_pair(24'hC0FFEE);
    push_pair(24'hBEEF01);
    push_pair(24'h777777);
    push_pair(24'h888888);
    cycles(8);
    chk("t4_two_reads", rd_count, r0 + 2);
    enable    = 1'b0;
    host_full = 1'b0;
    cycles(10);
    chk("t4_group_done", wr_count, base + 3);
    chk("t4_no_rd_disabled", rd_count, r0 + 2);
    enable = 1'b1;
    wait_words(base + 6, 60);

    // Overrun set, hold, clear
    cycles(2);
    rx_fifo_full = 1'b1;
    cycles(1);
    rx_fifo_full = 1'b0;
    chk("t5_overrun_set", {31'd0, overrun}, 32'd1);
    cycles(3);
    chk("t5_overrun_hold", {31'd0, overrun}, 32'd1);
    enable = 1'b0;
    cycles(1);
    enable = 1'b1;
    chk("t5_overrun_clear", {31'd0, overrun}, 32'd0);

    // Randomised stream of 257 groups with random empty/full back-pressure
    base = wr_count;
    for (int i = 0; i < 514; i++) push_pair(24'($urandom));
    n = 0;
    while (wr_count < base + 771 && n < 20000) begin
      @(posedge clk);
      #1;
      force_empty = ($urandom_range(0, 3) == 0);
      host_full   = ($urandom_range(0, 2) == 0);
      n++;
    end
    force_empty = 1'b0;
    host_full   = 1'b0;
    checks++;
    if (wr_count < base + 771) begin
      failures++;
      $display("FAIL t6_timeout actual=%0d required=%0d", wr_count, base + 771);
    end
    cycles(3);
    chk("t6_group_cnt_wrap", {24'd0, group_cnt}, (wr_count / 3) % 256);
    chk("t6_scoreboard_empty", exp_q.size(), 32'd0);
    chk("t6_all_pairs_read", rd_idx, wr_idx);

    // Reset asserted mid-group
    host_full = 1'b1;
    push_pair(24'h0F0F0F);
    push_pair(24'hF0F0F0);
    push_pair(24'h999999);
    cycles(8);
    reset_n   = 1'b0;
    host_full = 1'b0;
    @(negedge clk);
    chk("rst_mid_wr", {31'd0, host_wr}, 32'd0);
    chk("rst_mid_rd", {31'd0, rx_fifo_rd}, 32'd0);
    chk("rst_mid_data", {16'd0, host_data}, 32'd0);
    chk("rst_mid_group_cnt", {24'd0, group_cnt}, 32'd0);
    enable = 1'b0;
    cycles(1);
    reset_n = 1'b1;
    base    = wr_count;
    cycles(10);
    chk("rst_mid_no_writes", wr_count, base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
